// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDR SDRAM device responder: command decode, bank/timing tracking, burst engine, word array
// Read beats leave through a CL-dependent pipeline; protocol and timing violations latch into sticky err bits.
module sdram_responder #(
    parameter int BA_WIDTH  = 2,
    parameter int ROW_WIDTH = 13,
    parameter int COL_WIDTH = 9,
    parameter int MEM_AW    = 10,
    parameter int tRCD      = 3,
    parameter int tRP       = 2,
    parameter int tRC       = 7,
    parameter int tMRD      = 2
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst_n,
    input  logic                cke_i,
    input  logic                cs_n_i,
    input  logic                ras_i,
    input  logic                cas_i,
    input  logic                we_i,
    input  logic [BA_WIDTH-1:0] ba_i,
    input  logic [12:0]         a_i,
    input  logic [15:0]         dq_i,
    input  logic [1:0]          dqm_i,
    output logic [15:0]         dq_o,
    output logic                dq_oe_o,
    output logic [6:0]          mode_o,
    output logic [5:0]          err_o
);

    localparam int NB = 1 << BA_WIDTH;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        BURST_IDLE,
        BURST_RD,
        BURST_WR
    } burst_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [BA_WIDTH-1:0] b,
                                                  input logic [ROW_WIDTH-1:0] r,
                                                  input logic [COL_WIDTH-1:0] c);
        return MEM_AW'({b, r, c});
    endfunction

    // Only the low log2(BL) column bits move; the rest stay pinned to the start column.
    function automatic logic [COL_WIDTH-1:0] burst_col(input logic [COL_WIDTH-1:0] base,
                                                       input logic [COL_WIDTH-1:0] idx,
                                                       input logic [COL_WIDTH-1:0] mask,
                                                       input logic                 inter);
        logic [COL_WIDTH-1:0] moved;
        moved = inter ? (base ^ idx) : (base + idx);
        return (base & ~mask) | (moved & mask);
    endfunction

    // Bank state and timers
    logic [NB-1:0]        bank_act_q, bank_act_d;
    logic [ROW_WIDTH-1:0] open_row_q [NB];
    logic [ROW_WIDTH-1:0] open_row_d [NB];
    logic [3:0]           act_cnt_q [NB];
    logic [3:0]           act_cnt_d [NB];
    logic [3:0]           pre_cnt_q [NB];
    logic [3:0]           pre_cnt_d [NB];
    logic [3:0]           gcnt_q, gcnt_d;
    logic                 last_ref_q, last_ref_d;
    logic                 mrs_done_q, mrs_done_d;
    logic [6:0]           mode_q, mode_d;
    logic                 wb_single_q, wb_single_d;
    logic [5:0]           err_q, err_d;

    // Burst engine and read pipeline
    burst_e               burst_q, burst_d;
    logic [BA_WIDTH-1:0]  bst_bank_q, bst_bank_d;
    logic [ROW_WIDTH-1:0] bst_row_q, bst_row_d;
    logic [COL_WIDTH-1:0] bst_base_q, bst_base_d;
    logic [COL_WIDTH-1:0] bst_idx_q, bst_idx_d;
    logic [3:0]           bst_left_q, bst_left_d;
    logic                 bst_ap_q, bst_ap_d;
    logic                 pipe_vld_q, pipe_vld_d;
    logic [15:0]          pipe_data_q, pipe_data_d;
    logic [1:0]           dqm_q, dqm_d;
    logic [15:0]          dq_q, dq_d;
    logic                 dq_oe_q, dq_oe_d;

    logic [15:0]          mem_q [1 << MEM_AW];
    logic                 mem_we;
    logic [MEM_AW-1:0]    mem_waddr;
    logic [15:0]          mem_wdata;
    logic [1:0]           mem_be;

    // Mode decode
    logic                 cl3;
    logic                 bl_fp;
    logic [3:0]           bl_len;
    logic [COL_WIDTH-1:0] bl_mask;

    always_comb begin
        cl3    = (mode_q[6:4] == 3'd3);
        bl_fp  = (mode_q[2:0] == 3'd7);
        bl_len = 4'd1;
        case (mode_q[2:0])
            3'd1:    bl_len = 4'd2;
            3'd2:    bl_len = 4'd4;
            3'd3:    bl_len = 4'd8;
            default: bl_len = 4'd1;
        endcase
        bl_mask = bl_fp ? '1 : COL_WIDTH'(bl_len - 4'd1);
    end

    logic                 cmd_v;
    cmd_e                 cmd;
    logic                 ends_burst;
    logic                 gtime_bad;
    logic [COL_WIDTH-1:0] cur_col;
    logic [15:0]          rd_data;
    logic                 beat_v;
    logic [15:0]          beat_data;
    logic [5:0]           err_new;

    always_comb begin
        bank_act_d  = bank_act_q;
        open_row_d  = open_row_q;
        gcnt_d      = sat_inc(gcnt_q);
        last_ref_d  = last_ref_q;
        mrs_done_d  = mrs_done_q;
        mode_d      = mode_q;
        wb_single_d = wb_single_q;
        burst_d     = burst_q;
        bst_bank_d  = bst_bank_q;
        bst_row_d   = bst_row_q;
        bst_base_d  = bst_base_q;
        bst_idx_d   = bst_idx_q;
        bst_left_d  = bst_left_q;
        bst_ap_d    = bst_ap_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_data_d = pipe_data_q;
        dqm_d       = dqm_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        err_new     = '0;
        beat_v      = 1'b0;
        beat_data   = '0;
        for (int b = 0; b < NB; b++) begin
            act_cnt_d[b] = sat_inc(act_cnt_q[b]);
            pre_cnt_d[b] = sat_inc(pre_cnt_q[b]);
        end

        cmd_v      = cke_i && !cs_n_i;
        cmd        = cmd_e'({ras_i, cas_i, we_i});
        ends_burst = cmd_v && (cmd == CMD_RD || cmd == CMD_WR || cmd == CMD_BST);
        gtime_bad  = last_ref_q ? (gcnt_q < 4'(tRC)) : (gcnt_q < 4'(tMRD));
        cur_col    = burst_col(bst_base_q, bst_idx_q, bl_mask, mode_q[3]);
        rd_data    = mem_q[mem_idx(bst_bank_q, bst_row_q, cur_col)];

        // With cke low the burst, pipeline and outputs all hold.
        if (cke_i) begin
            dqm_d = dqm_i;
            if (burst_q != BURST_IDLE) begin
                bst_idx_d = bst_idx_q + COL_WIDTH'(1);
                if (!bl_fp) begin
                    bst_left_d = bst_left_q - 4'd1;
                    if (bst_left_q == 4'd1) begin
                        burst_d = BURST_IDLE;
                        if (burst_q == BURST_RD && bst_ap_q) begin
                            bank_act_d[bst_bank_q] = 1'b0;
                            pre_cnt_d[bst_bank_q]  = 4'd1;
                        end
                    end
                end
                if (burst_q == BURST_WR && !ends_burst) begin
                    mem_we    = 1'b1;
                    mem_waddr = mem_idx(bst_bank_q, bst_row_q, cur_col);
                    mem_wdata = dq_i;
                    mem_be    = ~dqm_i;
                end
            end
            if (cl3) begin
                pipe_vld_d  = (burst_q == BURST_RD);
                pipe_data_d = rd_data;
                beat_v      = pipe_vld_q;
                beat_data   = pipe_data_q;
            end else begin
                pipe_vld_d  = 1'b0;
                pipe_data_d = '0;
                beat_v      = (burst_q == BURST_RD);
                beat_data   = rd_data;
            end
            // dqm_q was sampled one edge earlier, giving the two-cycle read mask latency.
            dq_oe_d = beat_v && !(|dqm_q);
            dq_d    = dq_oe_d ? beat_data : '0;
        end

        if (cmd_v && cmd != CMD_NOP) begin
            if (gtime_bad) err_new[4] = 1'b1;
            if (ends_burst) burst_d = BURST_IDLE;
            case (cmd)
                CMD_ACT: begin
                    if (!mrs_done_q) err_new[5] = 1'b1;
                    if (bank_act_q[ba_i] || act_cnt_q[ba_i] < 4'(tRC)) err_new[1] = 1'b1;
                    if (pre_cnt_q[ba_i] < 4'(tRP)) err_new[3] = 1'b1;
                    bank_act_d[ba_i] = 1'b1;
                    open_row_d[ba_i] = a_i[ROW_WIDTH-1:0];
                    act_cnt_d[ba_i]  = 4'd1;
                end
                CMD_RD, CMD_WR: begin
                    if (!mrs_done_q) err_new[5] = 1'b1;
                    if (!bank_act_q[ba_i]) begin
                        err_new[0] = 1'b1;
                    end else begin
                        if (act_cnt_q[ba_i] < 4'(tRCD)) err_new[2] = 1'b1;
                        bst_bank_d = ba_i;
                        bst_row_d  = open_row_q[ba_i];
                        bst_base_d = a_i[COL_WIDTH-1:0];
                        if (cmd == CMD_RD) begin
                            burst_d    = BURST_RD;
                            bst_idx_d  = '0;
                            bst_left_d = bl_len;
                            bst_ap_d   = a_i[10];
                        end else begin
                            mem_we     = 1'b1;
                            mem_waddr  = mem_idx(ba_i, open_row_q[ba_i], a_i[COL_WIDTH-1:0]);
                            mem_wdata  = dq_i;
                            mem_be     = ~dqm_i;
                            bst_idx_d  = COL_WIDTH'(1);
                            bst_left_d = bl_len - 4'd1;
                            bst_ap_d   = 1'b0;
                            if (!wb_single_q && (bl_fp || bl_len != 4'd1)) burst_d = BURST_WR;
                        end
                    end
                end
                CMD_PRE: begin
                    for (int b = 0; b < NB; b++) begin
                        if (a_i[10] || ba_i == BA_WIDTH'(b)) begin
                            bank_act_d[b] = 1'b0;
                            pre_cnt_d[b]  = 4'd1;
                        end
                    end
                end
                CMD_REF: begin
                    if (|bank_act_q) err_new[4] = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        if (pre_cnt_q[b] < 4'(tRP)) err_new[3] = 1'b1;
                    end
                    gcnt_d     = 4'd1;
                    last_ref_d = 1'b1;
                end
                CMD_MRS: begin
                    mode_d      = a_i[6:0];
                    wb_single_d = a_i[9];
                    mrs_done_d  = 1'b1;
                    if (!(a_i[6:4] == 3'd2 || a_i[6:4] == 3'd3)) err_new[5] = 1'b1;
                    if (a_i[2:0] > 3'd3 && a_i[2:0] != 3'd7) err_new[5] = 1'b1;
                    gcnt_d     = 4'd1;
                    last_ref_d = 1'b0;
                end
                default: ;
            endcase
        end
        err_d = err_q | err_new;
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            bank_act_q  <= '0;
            gcnt_q      <= 4'hF;
            last_ref_q  <= 1'b0;
            mrs_done_q  <= 1'b0;
            mode_q      <= '0;
            wb_single_q <= 1'b0;
            err_q       <= '0;
            burst_q     <= BURST_IDLE;
            bst_bank_q  <= '0;
            bst_row_q   <= '0;
            bst_base_q  <= '0;
            bst_idx_q   <= '0;
            bst_left_q  <= '0;
            bst_ap_q    <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            dqm_q       <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                open_row_q[b] <= '0;
                act_cnt_q[b]  <= 4'hF;
                pre_cnt_q[b]  <= 4'hF;
            end
        end else begin
            bank_act_q  <= bank_act_d;
            open_row_q  <= open_row_d;
            act_cnt_q   <= act_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            gcnt_q      <= gcnt_d;
            last_ref_q  <= last_ref_d;
            mrs_done_q  <= mrs_done_d;
            mode_q      <= mode_d;
            wb_single_q <= wb_single_d;
            err_q       <= err_d;
            burst_q     <= burst_d;
            bst_bank_q  <= bst_bank_d;
            bst_row_q   <= bst_row_d;
            bst_base_q  <= bst_base_d;
            bst_idx_q   <= bst_idx_d;
            bst_left_q  <= bst_left_d;
            bst_ap_q    <= bst_ap_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            dqm_q       <= dqm_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    // Array contents are undefined after reset, so the storage itself is not reset.
    always_ff @(posedge sdram_clk) begin
        if (mem_we) begin
            if (mem_be[0]) mem_q[mem_waddr][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem_q[mem_waddr][15:8] <= mem_wdata[15:8];
        end
    end

    assign dq_o    = dq_q;
    assign dq_oe_o = dq_oe_q;
    assign mode_o  = mode_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - scoreboard bench for sdram_responder
// Read beats are queued with their expected cycle when a READ is issued and popped by the negedge monitor.
module tb_sdram_responder;

    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst_n;
    logic        cke_i, cs_n_i, ras_i, cas_i, we_i;
    logic [1:0]  ba_i;
    logic [12:0] a_i;
    logic [15:0] dq_i;
    logic [1:0]  dqm_i;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [6:0]  mode_o;
    logic [5:0]  err_o;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] model [512];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    sdram_responder dut (
        .sdram_clk  (sdram_clk),
        .sdram_rst_n(sdram_rst_n),
        .cke_i      (cke_i),
        .cs_n_i     (cs_n_i),
        .ras_i      (ras_i),
        .cas_i      (cas_i),
        .we_i       (we_i),
        .ba_i       (ba_i),
        .a_i        (a_i),
        .dq_i       (dq_i),
        .dqm_i      (dqm_i),
        .dq_o       (dq_o),
        .dq_oe_o    (dq_oe_o),
        .mode_o     (mode_o),
        .err_o      (err_o)
    );

    always #5 sdram_clk = ~sdram_clk;
    always @(posedge sdram_clk) cyc <= cyc + 1;

    always @(negedge sdram_clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_beat exp_cyc=%0d now=%0d exp=%h", exp_q[0].cyc, cyc, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (dq_oe_o === 1'b1) begin
            beat_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat cyc=%0d got=%h", cyc, dq_o);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || dq_o !== e.data) begin
                    failures++;
                    $display("FAIL beat cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, dq_o, e.cyc, e.data);
                end
            end
        end
    end

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] m);
        {ras_i, cas_i, we_i} = c;
        ba_i = b; a_i = a; dq_i = d; dqm_i = m;
        @(posedge sdram_clk);
        #1;
        {ras_i, cas_i, we_i} = C_NOP;
        ba_i = '0; a_i = '0; dq_i = '0; dqm_i = '0;
    endtask

    task automatic nop(input int n);
        repeat (n) cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic do_write(input logic [8:0] col, input logic [15:0] d, input logic [1:0] m);
        cmd(C_WR, 2'd1, {4'd0, col}, d, m);
        if (!m[0]) model[col][7:0]  = d[7:0];
        if (!m[1]) model[col][15:8] = d[15:8];
    endtask

    task automatic push_beat(input int c, input logic [15:0] d);
        beat_t e;
        e.cyc = c; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_read(input int n, input logic [8:0] base, input int bl, input bit inter,
                            input int cl, input int nbeats);
        logic [8:0] mask, col, k9;
        mask = 9'(bl - 1);
        for (int k = 0; k < nbeats; k++) begin
            k9  = 9'(k);
            col = inter ? ((base & ~mask) | ((base ^ k9) & mask))
                        : ((base & ~mask) | ((base + k9) & mask));
            push_beat(n + cl + k - 1, model[col]);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (err_o !== 6'h00 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s err=%h pending=%0d exp err=00 pending=0", name, err_o, exp_q.size());
        end
    endtask

    task automatic test_reset;
        checks += 4;
        if (dq_oe_o !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", dq_oe_o); end
        if (dq_o !== 16'h0)   begin failures++; $display("FAIL reset_dq got=%h exp=0", dq_o); end
        if (mode_o !== 7'h0)  begin failures++; $display("FAIL reset_mode got=%h exp=0", mode_o); end
        if (err_o !== 6'h0)   begin failures++; $display("FAIL reset_err got=%h exp=0", err_o); end
    endtask

    task automatic test_init;
        cmd(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        nop(1);
        repeat (8) begin
            cmd(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
            nop(6);
        end
        cmd(C_MRS, 2'd0, 13'h221, 16'd0, 2'b00);
        nop(1);
        checks++;
        if (mode_o !== 7'h21) begin failures++; $display("FAIL init_mode got=%h exp=21", mode_o); end
        check_idle("init_err");
    endtask

    task automatic test_write_read;
        int n;
        cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
        nop(2);
        do_write(9'd4, 16'hA5A5, 2'b00);
        do_write(9'd5, 16'h5A5A, 2'b00);
        cmd(C_RD, 2'd1, 13'd4, 16'd0, 2'b00);
        n = cyc;
        push_beat(n + 1, 16'hA5A5);
        push_beat(n + 2, 16'h5A5A);
        nop(6);
        check_idle("write_read");
    endtask

    task automatic test_byte_mask;
        int n;
        do_write(9'd8, 16'hFFFF, 2'b00);
        do_write(9'd8, 16'h1234, 2'b10);
        do_write(9'd9, 16'h00C3, 2'b00);
        do_write(9'd9, 16'hAB00, 2'b01);
        cmd(C_RD, 2'd1, 13'd8, 16'd0, 2'b00);
        n = cyc;
        push_beat(n + 1, 16'hFF34);
        push_beat(n + 2, 16'hABC3);
        nop(6);
        check_idle("byte_mask");
    endtask

    task automatic test_read_dqm;
        int n;
        cmd(C_RD, 2'd1, 13'd4, 16'd0, 2'b00);
        n = cyc;
        exp_read(n, 9'd4, 2, 1'b0, 2, 1);
        cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'b11);
        nop(5);
        check_idle("read_dqm");
    endtask

    task automatic test_cl3_interleave;
        int n;
        cmd(C_MRS, 2'd0, 13'h239, 16'd0, 2'b00);
        nop(1);
        checks++;
        if (mode_o !== 7'h39) begin failures++; $display("FAIL cl3_mode got=%h exp=39", mode_o); end
        cmd(C_RD, 2'd1, 13'd5, 16'd0, 2'b00);
        n = cyc;
        push_beat(n + 2, 16'h5A5A);
        push_beat(n + 3, 16'hA5A5);
        nop(7);
        check_idle("cl3_interleave");
    endtask

    task automatic test_bl8_interrupt;
        int n1, n2;
        cmd(C_MRS, 2'd0, 13'h223, 16'd0, 2'b00);
        nop(1);
        checks++;
        if (mode_o !== 7'h23) begin failures++; $display("FAIL bl8_mode got=%h exp=23", mode_o); end
        for (int c = 0; c < 16; c++) do_write(9'(c), 16'($urandom), 2'b00);
        cmd(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
        n1 = cyc;
        exp_read(n1, 9'd0, 8, 1'b0, 2, 2);
        nop(1);
        cmd(C_RD, 2'd1, 13'd8, 16'd0, 2'b00);
        n2 = cyc;
        exp_read(n2, 9'd8, 8, 1'b0, 2, 8);
        nop(12);
        check_idle("bl8_interrupt");
    endtask

    task automatic test_errors;
        bit saw_oe = 1'b0;
        cmd(C_RD, 2'd2, 13'd0, 16'd0, 2'b00);
        checks++;
        if (err_o !== 6'h01) begin failures++; $display("FAIL idle_read_err got=%h exp=01", err_o); end
        repeat (4) begin
            nop(1);
            if (dq_oe_o !== 1'b0) saw_oe = 1'b1;
        end
        checks++;
        if (saw_oe) begin failures++; $display("FAIL idle_read_oe got=1 exp=0"); end
        cmd(C_PRE, 2'd1, 13'd0, 16'd0, 2'b00);
        cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
        checks++;
        if (err_o !== 6'h09) begin failures++; $display("FAIL act_trp_err got=%h exp=09", err_o); end
    endtask

    task automatic test_reset_mid_burst;
        int n;
        nop(2);
        cmd(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
        n = cyc;
        exp_read(n, 9'd0, 8, 1'b0, 2, 8);
        nop(2);
        #2;
        checks++;
        if (dq_oe_o !== 1'b1) begin failures++; $display("FAIL pre_reset_oe got=%b exp=1", dq_oe_o); end
        sdram_rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks += 3;
        if (dq_oe_o !== 1'b0) begin failures++; $display("FAIL async_reset_oe got=%b exp=0", dq_oe_o); end
        if (err_o !== 6'h0)   begin failures++; $display("FAIL async_reset_err got=%h exp=0", err_o); end
        if (mode_o !== 7'h0)  begin failures++; $display("FAIL async_reset_mode got=%h exp=0", mode_o); end
        repeat (3) @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        nop(8);
        check_idle("post_reset");
    endtask

    initial begin
        sdram_rst_n = 1'b0;
        cke_i = 1'b1; cs_n_i = 1'b0;
        {ras_i, cas_i, we_i} = C_NOP;
        ba_i = '0; a_i = '0; dq_i = '0; dqm_i = '0;
        repeat (3) @(posedge sdram_clk);
        #1;
        test_reset;
        @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        test_init;
        test_write_read;
        test_byte_mask;
        test_read_dqm;
        test_cl3_interleave;
        test_bl8_interrupt;
        test_errors;
        test_reset_mid_burst;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
